// File: rtl/minimac2_defs.sv
// Shared constants for the minimac2 receive writer: FSM encoding, framing and CRC-32 values.
package minimac2_defs;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StPreamble = 2'd1,
        StData     = 2'd2,
        StDiscard  = 2'd3
    } state_t;

    localparam logic [3:0]  SfdNibble     = 4'hD;
    localparam logic [31:0] CrcPoly       = 32'hEDB8_8320;
    localparam logic [31:0] CrcInit       = 32'hFFFF_FFFF;
    localparam logic [31:0] CrcResidue    = 32'hDEBB_20E3;
    localparam int unsigned MaxFrameLimit = 2048;

endpackage

// File: rtl/minimac2_rx_writer_if.sv
// MII receive side, slot handshake and ping-pong buffer write ports of the receive writer.
interface minimac2_rx_writer_if;

    logic        phy_dv;
    logic        phy_rx_er;
    logic [3:0]  phy_rx_data;
    logic        rx_ready0;
    logic        rx_ready1;
    logic [7:0]  rxb0_dat;
    logic [7:0]  rxb1_dat;
    logic [10:0] rxb0_adr;
    logic [10:0] rxb1_adr;
    logic        rxb0_we;
    logic        rxb1_we;
    logic        rx_done0;
    logic        rx_done1;
    logic [11:0] rx_count0;
    logic [11:0] rx_count1;
    logic        rx_error;
    logic        rx_overflow;

    modport master (
        input  phy_dv, phy_rx_er, phy_rx_data, rx_ready0, rx_ready1,
        output rxb0_dat, rxb1_dat, rxb0_adr, rxb1_adr, rxb0_we, rxb1_we,
        output rx_done0, rx_done1, rx_count0, rx_count1, rx_error, rx_overflow
    );

    modport slave (
        output phy_dv, phy_rx_er, phy_rx_data, rx_ready0, rx_ready1,
        input  rxb0_dat, rxb1_dat, rxb0_adr, rxb1_adr, rxb0_we, rxb1_we,
        input  rx_done0, rx_done1, rx_count0, rx_count1, rx_error, rx_overflow
    );

endinterface

// File: rtl/minimac2_crc32.sv
// Combinational byte step of the reflected CRC-32 (LSB first), no inversion.
module minimac2_crc32
    import minimac2_defs::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] result
);

    always_comb begin
        result = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            result = result[0] ? ((result >> 1) ^ CrcPoly) : (result >> 1);
        end
    end

endmodule

// File: rtl/minimac2_rx_writer.sv
// MII receive front end: strips preamble, writes bytes into a ping-pong slot, checks length and FCS.
module minimac2_rx_writer
    import minimac2_defs::*;
#(
    parameter int unsigned MIN_FRAME = 64,
    parameter int unsigned MAX_FRAME = 2048,
    parameter bit          CRC_CHECK = 1'b1
) (
    input logic                  phy_rx_clk,
    input logic                  sys_rst_n,
    minimac2_rx_writer_if.master bus
);

    localparam logic [11:0] MinCount = 12'(MIN_FRAME);
    // Slot address is 11 bits, so the limit is clamped to the buffer size.
    localparam logic [11:0] MaxCount =
        (MAX_FRAME > MaxFrameLimit) ? 12'(MaxFrameLimit) : 12'(MAX_FRAME);

    state_t      state;
    logic        slot;
    logic [3:0]  low_nib;
    logic        phase;
    logic [11:0] count;
    logic [31:0] crc;
    logic        hold0;
    logic        hold1;

    logic        avail0;
    logic        avail1;
    logic [7:0]  byte_val;
    logic [31:0] crc_next;
    logic        frame_bad;

    assign avail0    = bus.rx_ready0 & ~hold0;
    assign avail1    = bus.rx_ready1 & ~hold1;
    assign byte_val  = {bus.phy_rx_data, low_nib};
    assign frame_bad = phase | (count < MinCount) | (CRC_CHECK && (crc != CrcResidue));

    minimac2_crc32 u_crc (
        .crc    (crc),
        .data   (byte_val),
        .result (crc_next)
    );

    always_ff @(posedge phy_rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state           <= StIdle;
            slot            <= 1'b0;
            low_nib         <= 4'h0;
            phase           <= 1'b0;
            count           <= 12'd0;
            crc             <= CrcInit;
            hold0           <= 1'b0;
            hold1           <= 1'b0;
            bus.rxb0_dat    <= 8'h00;
            bus.rxb1_dat    <= 8'h00;
            bus.rxb0_adr    <= 11'd0;
            bus.rxb1_adr    <= 11'd0;
            bus.rxb0_we     <= 1'b0;
            bus.rxb1_we     <= 1'b0;
            bus.rx_done0    <= 1'b0;
            bus.rx_done1    <= 1'b0;
            bus.rx_count0   <= 12'd0;
            bus.rx_count1   <= 12'd0;
            bus.rx_error    <= 1'b0;
            bus.rx_overflow <= 1'b0;
        end else begin
            bus.rxb0_dat    <= 8'h00;
            bus.rxb1_dat    <= 8'h00;
            bus.rxb0_adr    <= 11'd0;
            bus.rxb1_adr    <= 11'd0;
            bus.rxb0_we     <= 1'b0;
            bus.rxb1_we     <= 1'b0;
            bus.rx_done0    <= 1'b0;
            bus.rx_done1    <= 1'b0;
            bus.rx_error    <= 1'b0;
            bus.rx_overflow <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (bus.phy_dv) begin
                        if (avail0) begin
                            slot  <= 1'b0;
                            state <= StPreamble;
                        end else if (avail1) begin
                            slot  <= 1'b1;
                            state <= StPreamble;
                        end else begin
                            bus.rx_overflow <= 1'b1;
                            state           <= StDiscard;
                        end
                    end
                end
                StPreamble: begin
                    if (!bus.phy_dv) begin
                        state <= StIdle;
                    end else if (bus.phy_rx_er) begin
                        bus.rx_error <= 1'b1;
                        state        <= StDiscard;
                    end else if (bus.phy_rx_data == SfdNibble) begin
                        phase <= 1'b0;
                        count <= 12'd0;
                        crc   <= CrcInit;
                        state <= StData;
                    end
                end
                StData: begin
                    if (bus.phy_rx_er) begin
                        bus.rx_error <= 1'b1;
                        state        <= StDiscard;
                    end else if (!bus.phy_dv) begin
                        // The last byte's CRC update has already landed, so judge now.
                        state <= StIdle;
                        if (frame_bad) begin
                            bus.rx_error <= 1'b1;
                        end else if (!slot) begin
                            bus.rx_done0  <= 1'b1;
                            bus.rx_count0 <= count;
                            hold0         <= 1'b1;
                        end else begin
                            bus.rx_done1  <= 1'b1;
                            bus.rx_count1 <= count;
                            hold1         <= 1'b1;
                        end
                    end else if (!phase) begin
                        low_nib <= bus.phy_rx_data;
                        phase   <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (count == MaxCount) begin
                            bus.rx_error <= 1'b1;
                            state        <= StDiscard;
                        end else begin
                            if (!slot) begin
                                bus.rxb0_we  <= 1'b1;
                                bus.rxb0_dat <= byte_val;
                                bus.rxb0_adr <= count[10:0];
                            end else begin
                                bus.rxb1_we  <= 1'b1;
                                bus.rxb1_dat <= byte_val;
                                bus.rxb1_adr <= count[10:0];
                            end
                            count <= count + 12'd1;
                            crc   <= crc_next;
                        end
                    end
                end
                StDiscard: begin
                    if (!bus.phy_dv) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase

            // Control releases a held slot by dropping its ready level.
            if (!bus.rx_ready0) begin
                hold0 <= 1'b0;
            end
            if (!bus.rx_ready1) begin
                hold1 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_minimac2_rx_writer.sv
// Directed bench for minimac2_rx_writer: slot ping-pong, FCS/length errors, overflow, async reset.
module tb_minimac2_rx_writer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    minimac2_rx_writer_if bus ();

    minimac2_rx_writer #(
        .MIN_FRAME (64),
        .MAX_FRAME (2048),
        .CRC_CHECK (1'b1)
    ) dut (
        .phy_rx_clk (clk),
        .sys_rst_n  (rst_n),
        .bus        (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] frame [0:2100];
    logic [7:0] mem0 [0:2047];
    logic [7:0] mem1 [0:2047];
    int wcnt0, wcnt1, done0, done1, errs, ovfs, first_adr0, last_adr0;

    always @(negedge clk) begin
        if (bus.rxb0_we) begin
            mem0[bus.rxb0_adr] = bus.rxb0_dat;
            if (first_adr0 < 0) first_adr0 = int'(bus.rxb0_adr);
            last_adr0 = int'(bus.rxb0_adr);
            wcnt0++;
        end
        if (bus.rxb1_we) begin
            mem1[bus.rxb1_adr] = bus.rxb1_dat;
            wcnt1++;
        end
        if (bus.rx_done0) done0++;
        if (bus.rx_done1) done1++;
        if (bus.rx_error) errs++;
        if (bus.rx_overflow) ovfs++;
    end

    initial begin
        #2_000_000;
        $error("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Payload i[7:0], optional flip of byte 10 after the FCS is computed, then LSB-first FCS.
    task automatic build_frame(input int len, input bit flip);
        logic [31:0] c;
        logic [31:0] fcs;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len - 4; i++) begin
            frame[i] = 8'(i);
            c = crc_byte(c, frame[i]);
        end
        fcs = ~c;
        for (int k = 0; k < 4; k++) frame[len - 4 + k] = fcs[8*k +: 8];
        if (flip) frame[10] = frame[10] ^ 8'h01;
    endtask

    task automatic clear();
        @(posedge clk);
        #1;
        wcnt0 = 0; wcnt1 = 0; done0 = 0; done1 = 0; errs = 0; ovfs = 0;
        first_adr0 = -1; last_adr0 = -1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); bus.phy_dv = 1'b1; bus.phy_rx_data = b[3:0];
        @(negedge clk); bus.phy_rx_data = b[7:4];
    endtask

    task automatic send_frame(input int len, input int er_at, input int rst_at);
        for (int i = 0; i < 7; i++) send_byte(8'h55);
        send_byte(8'hD5);
        for (int i = 0; i < len; i++) begin
            if (i == rst_at) begin
                @(negedge clk); bus.phy_dv = 1'b1; bus.phy_rx_data = frame[i][3:0];
                #2 rst_n = 1'b0;
                #1;
                check("rst_we0", 32'(bus.rxb0_we), 0);
                check("rst_adr0", 32'(bus.rxb0_adr), 0);
                check("rst_count0", 32'(bus.rx_count0), 0);
                check("rst_error", 32'(bus.rx_error), 0);
                bus.phy_dv = 1'b0;
                @(negedge clk); rst_n = 1'b1;
                repeat (4) @(negedge clk);
                return;
            end
            if (i == er_at) begin
                @(negedge clk); bus.phy_rx_er = 1'b1; bus.phy_rx_data = frame[i][3:0];
                break;
            end
            send_byte(frame[i]);
        end
        @(negedge clk); bus.phy_dv = 1'b0; bus.phy_rx_er = 1'b0; bus.phy_rx_data = 4'h0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ack();
        @(negedge clk); bus.rx_ready0 = 1'b0; bus.rx_ready1 = 1'b0;
        @(negedge clk); bus.rx_ready0 = 1'b1; bus.rx_ready1 = 1'b1;
    endtask

    task automatic check_data0(input string tag, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) if (mem0[i] !== frame[i]) bad++;
        check(tag, 32'(bad), 0);
    endtask

    task automatic check_data1(input string tag, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) if (mem1[i] !== frame[i]) bad++;
        check(tag, 32'(bad), 0);
    endtask

    initial begin
        bus.phy_dv = 1'b0; bus.phy_rx_er = 1'b0; bus.phy_rx_data = 4'h0;
        bus.rx_ready0 = 1'b1; bus.rx_ready1 = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_we0", 32'(bus.rxb0_we), 0);
        check("reset_done0", 32'(bus.rx_done0), 0);
        check("reset_count1", 32'(bus.rx_count1), 0);
        check("reset_error", 32'(bus.rx_error), 0);
        check("reset_overflow", 32'(bus.rx_overflow), 0);
        rst_n = 1'b1;

        // Good frame into slot 0
        build_frame(64, 1'b0);
        clear(); send_frame(64, -1, -1);
        check("t1_writes0", 32'(wcnt0), 64);
        check("t1_writes1", 32'(wcnt1), 0);
        check("t1_last_adr", 32'(last_adr0), 63);
        check_data0("t1_data0", 64);
        check("t1_done0", 32'(done0), 1);
        check("t1_count0", 32'(bus.rx_count0), 64);
        check("t1_error", 32'(errs), 0);

        // Slot 0 held, so the next frame lands in slot 1
        clear(); send_frame(64, -1, -1);
        check("t2_writes1", 32'(wcnt1), 64);
        check("t2_writes0", 32'(wcnt0), 0);
        check_data1("t2_data1", 64);
        check("t2_done1", 32'(done1), 1);
        check("t2_count1", 32'(bus.rx_count1), 64);
        @(negedge clk); bus.rx_ready0 = 1'b0;
        @(negedge clk); bus.rx_ready0 = 1'b1;
        clear(); send_frame(64, -1, -1);
        check("t2_writes0_again", 32'(wcnt0), 64);
        check("t2_first_adr", 32'(first_adr0), 0);
        check("t2_done0", 32'(done0), 1);

        // Corrupted payload: written but rejected, slot not held
        ack();
        build_frame(64, 1'b1);
        clear(); send_frame(64, -1, -1);
        check("t3_writes0", 32'(wcnt0), 64);
        check("t3_error", 32'(errs), 1);
        check("t3_done0", 32'(done0), 0);
        build_frame(64, 1'b0);
        clear(); send_frame(64, -1, -1);
        check("t3_next_writes0", 32'(wcnt0), 64);
        check("t3_next_done0", 32'(done0), 1);

        // No free slot
        @(negedge clk); bus.rx_ready0 = 1'b0; bus.rx_ready1 = 1'b0;
        clear(); send_frame(64, -1, -1);
        check("t4_overflow", 32'(ovfs), 1);
        check("t4_writes", 32'(wcnt0 + wcnt1), 0);
        check("t4_done", 32'(done0 + done1), 0);
        @(negedge clk); bus.rx_ready0 = 1'b1; bus.rx_ready1 = 1'b1;
        clear(); send_frame(64, -1, -1);
        check("t4_after_done0", 32'(done0), 1);
        check("t4_after_writes0", 32'(wcnt0), 64);

        // phy_rx_er at byte 20
        ack();
        clear(); send_frame(64, 20, -1);
        check("t5a_writes0", 32'(wcnt0), 20);
        check("t5a_error", 32'(errs), 1);
        check("t5a_done0", 32'(done0), 0);

        // Oversize frame
        build_frame(2049, 1'b0);
        clear(); send_frame(2049, -1, -1);
        check("t5b_writes0", 32'(wcnt0), 2048);
        check("t5b_last_adr", 32'(last_adr0), 2047);
        check("t5b_error", 32'(errs), 1);
        check("t5b_done0", 32'(done0), 0);

        // Runt with valid FCS
        build_frame(40, 1'b0);
        clear(); send_frame(40, -1, -1);
        check("t5c_writes0", 32'(wcnt0), 40);
        check("t5c_error", 32'(errs), 1);
        check("t5c_done0", 32'(done0), 0);

        // Asynchronous reset mid-frame, then a clean frame
        build_frame(64, 1'b0);
        clear(); send_frame(64, -1, 30);
        check("t6_done0", 32'(done0), 0);
        clear(); send_frame(64, -1, -1);
        check("t6_after_done0", 32'(done0), 1);
        check("t6_after_count0", 32'(bus.rx_count0), 64);
        check_data0("t6_after_data0", 64);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
